rv_exec_monitor: RTL and testbench

Synthesizable execution monitor that sits beside the multicycle RISC-V core (rv_mc) and observes its fetch strobe, PC and register-file write port. It counts retired instructions and cycles, and detects program completion by self-loop (stuck PC), timeout or optional EBREAK. It buffers register-write trace records in a parametrised FIFO so a bench or debug port can drain them. Generalises hang detection and reg-write monitoring into a reusable parametrised block.

---
 rtl/rv_mon_pkg.sv | 22 ++
 rtl/rv_mon_trace_fifo.sv | 66 ++++++
 rtl/rv_exec_monitor.sv | 132 +++++++++++++
 tb/tb_rv_exec_monitor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mon_pkg.sv
// Shared types and constants for the rv_mc execution monitor and its trace FIFO.
package rv_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_STUCK   = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_EBREAK  = 2'b11;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  // Trace record layout: {fetch pc, rd address, rd data}.
  function automatic int trace_width(input int xlen);
    return 2 * xlen + 5;
  endfunction

endpackage

// File: rtl/rv_mon_trace_fifo.sv
// Synchronous FIFO with a registered head; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module rv_mon_trace_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop_req,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_nxt;
  logic [AW:0]      count, count_nxt;
  logic             empty, full, do_push, do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == (AW+1)'(DEPTH));
    do_pop  = pop_req && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
    rd_nxt  = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + (AW+1)'(1);
    else if (!do_push && do_pop)
      count_nxt = count - (AW+1)'(1);
  end

  assign valid = !empty;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      // The new head is either already stored or is the word being written now.
      if (count_nxt != '0) begin
        if (do_push && (rd_nxt == wr_ptr))
          dout <= din;
        else
          dout <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/rv_exec_monitor.sv
// Execution monitor for rv_mc: counts fetches/cycles, detects stuck/timeout halts
// and buffers register-write trace records. Build option: RV_MON_EBREAK_HALT_EN.
module rv_exec_monitor
  import rv_mon_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int STUCK_LIMIT    = 5,
  parameter int TIMEOUT_CYCLES = 300,
  parameter int TRACE_DEPTH    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            ir_we,
  input  logic [XLEN-1:0] instr,
  input  logic            rf_we,
  input  logic [4:0]      rf_waddr,
  input  logic [XLEN-1:0] rf_wdata,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [XLEN-1:0] trace_pc,
  output logic [4:0]      trace_addr,
  output logic [XLEN-1:0] trace_data,
  output logic            trace_overflow,
  output logic            done,
  output logic [1:0]      done_cause,
  output logic [XLEN-1:0] halt_pc,
  output logic [31:0]     instr_count,
  output logic [31:0]     cycle_count
);

  localparam int TW = trace_width(XLEN);
  localparam int SW = $clog2(STUCK_LIMIT + 1);
`ifdef RV_MON_EBREAK_HALT_EN
  localparam bit EBREAK_EN = 1'b1;
`else
  localparam bit EBREAK_EN = 1'b0;
`endif

  mon_state_t      state;
  logic [XLEN-1:0] last_fetch_pc;
  logic [SW-1:0]   same_cnt, same_inc;
  logic [31:0]     cycle_inc;
  logic            same_pc, is_ebreak, hit_stuck, hit_timeout;
  logic            trace_push, trace_drop;
  logic [TW-1:0]   trace_head;

  always_comb begin
    same_pc     = (pc == last_fetch_pc);
    same_inc    = same_cnt + SW'(1);
    cycle_inc   = cycle_count + 32'd1;
    is_ebreak   = EBREAK_EN && ir_we && (instr == XLEN'(EBREAK_INSTR));
    hit_stuck   = ir_we && same_pc && (same_inc == SW'(STUCK_LIMIT));
    hit_timeout = (cycle_inc == 32'(TIMEOUT_CYCLES));
    trace_push  = (state == ST_RUN) && rf_we && (rf_waddr != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      last_fetch_pc <= '0;
      same_cnt      <= '0;
      done          <= 1'b0;
      done_cause    <= CAUSE_NONE;
      halt_pc       <= '0;
      instr_count   <= '0;
      cycle_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ir_we) begin
            state         <= ST_RUN;
            instr_count   <= 32'd1;
            last_fetch_pc <= pc;
            same_cnt      <= '0;
          end
        end
        ST_RUN: begin
          cycle_count <= cycle_inc;
          if (ir_we) begin
            instr_count   <= instr_count + 32'd1;
            last_fetch_pc <= pc;
            same_cnt      <= same_pc ? same_inc : '0;
          end
          if (is_ebreak) begin
            state      <= ST_DONE;
            done       <= 1'b1;
            done_cause <= CAUSE_EBREAK;
            halt_pc    <= pc;
          end else if (hit_stuck) begin
            state      <= ST_DONE;
            done       <= 1'b1;
            done_cause <= CAUSE_STUCK;
            halt_pc    <= pc;
          end else if (hit_timeout) begin
            // Report the most recent fetch, including one landing on this edge.
            state      <= ST_DONE;
            done       <= 1'b1;
            done_cause <= CAUSE_TIMEOUT;
            halt_pc    <= ir_we ? pc : last_fetch_pc;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      trace_overflow <= 1'b0;
    else if (trace_drop)
      trace_overflow <= 1'b1;
  end

  rv_mon_trace_fifo #(
    .WIDTH (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (trace_push),
    .din     ({last_fetch_pc, rf_waddr, rf_wdata}),
    .pop_req (trace_ready),
    .valid   (trace_valid),
    .dout    (trace_head),
    .drop    (trace_drop)
  );

  assign {trace_pc, trace_addr, trace_data} = trace_head;

endmodule

// File: tb/tb_rv_exec_monitor.sv
// Directed bench for rv_exec_monitor: halt detection, counters, trace FIFO and reset.
module tb_rv_exec_monitor;
  import rv_mon_pkg::*;

  localparam int XLEN = 32;
  localparam int TW   = 2 * XLEN + 5;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBK = 32'h0010_0073;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic            ir_we = 1'b0;
  logic [XLEN-1:0] instr = '0;
  logic            rf_we = 1'b0;
  logic [4:0]      rf_waddr = '0;
  logic [XLEN-1:0] rf_wdata = '0;
  logic            trace_ready = 1'b0;
  logic            trace_valid, trace_overflow, done;
  logic [XLEN-1:0] trace_pc, trace_data, halt_pc;
  logic [4:0]      trace_addr;
  logic [1:0]      done_cause;
  logic [31:0]     instr_count, cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [TW-1:0] exp_q[$];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        exp_valid;
    logic        exp_ovf;
  } wr_vec_t;

  wr_vec_t tbl_a[4];
  wr_vec_t tbl_b[8];

  rv_exec_monitor dut (
    .clk(clk), .reset(reset), .pc(pc), .ir_we(ir_we), .instr(instr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_overflow(trace_overflow), .done(done), .done_cause(done_cause),
    .halt_pc(halt_pc), .instr_count(instr_count), .cycle_count(cycle_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0; ir_we = 1'b0; rf_we = 1'b0; trace_ready = 1'b0;
    pc = '0; instr = '0; rf_waddr = '0; rf_wdata = '0;
    tick();
    reset = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] p, input logic [31:0] ins);
    pc = p; instr = ins; ir_we = 1'b1;
    tick();
    ir_we = 1'b0; instr = '0;
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    tick();
    rf_we = 1'b0;
  endtask

  // Scoreboard
  task automatic check(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string nm);
    check({nm, "_done"}, done, 0);
    check({nm, "_cause"}, done_cause, CAUSE_NONE);
    check({nm, "_halt_pc"}, halt_pc, 0);
    check({nm, "_instr_count"}, instr_count, 0);
    check({nm, "_cycle_count"}, cycle_count, 0);
    check({nm, "_trace_valid"}, trace_valid, 0);
    check({nm, "_overflow"}, trace_overflow, 0);
    check({nm, "_trace_head"}, {trace_pc, trace_addr, trace_data}, 0);
  endtask

  task automatic drain(input string nm, input int max_pops);
    for (int k = 0; k < max_pops && trace_valid; k++) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_extra: actual %0h, expected no entry", nm, {trace_pc, trace_addr, trace_data});
      end else begin
        check({nm, "_entry"}, {trace_pc, trace_addr, trace_data}, exp_q.pop_front());
      end
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
    end
    check({nm, "_empty"}, trace_valid, 0);
    check({nm, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int first_done;

    tbl_a[0] = '{5'd0, 32'h33, 1'b0, 1'b0};
    tbl_a[1] = '{5'd5, 32'h1E, 1'b1, 1'b0};
    tbl_a[2] = '{5'd0, 32'h07, 1'b1, 1'b0};
    tbl_a[3] = '{5'd6, 32'h0A, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++)
      tbl_b[i] = '{5'(i + 1), 32'h100 + 32'(i), 1'b1, 1'b0};

    // Reset state
    do_reset();
    check_zero_outputs("reset");

    // Stuck PC: 0,4,8 then six fetches of 0x0C, one every 4 cycles
    fetch(32'h0, NOP); idle(3);
    fetch(32'h4, NOP); idle(3);
    fetch(32'h8, NOP); idle(3);
    for (int i = 0; i < 6; i++) begin
      fetch(32'hC, NOP);
      if (i == 4) check("stuck_not_yet", done, 0);
      if (i < 5) idle(3);
    end
    check("stuck_done", done, 1);
    check("stuck_cause", done_cause, CAUSE_STUCK);
    check("stuck_halt_pc", halt_pc, 32'hC);
    check("stuck_instr_count", instr_count, 9);
    check("stuck_cycle_count", cycle_count, 32);
    fetch(32'h100, NOP); idle(4);
    check("stuck_frozen_instr", instr_count, 9);
    check("stuck_frozen_cycle", cycle_count, 32);
    check("stuck_frozen_halt_pc", halt_pc, 32'hC);

    // Timeout: distinct PCs every 4 cycles
    do_reset();
    first_done = -1;
    for (int e = 0; e < 400; e++) begin
      ir_we = (e % 4 == 0) && (e < 300);
      pc = 32'(e * 4);
      tick();
      if (done && first_done < 0) first_done = e;
    end
    ir_we = 1'b0;
    check("timeout_edge", 32'(first_done), 300);
    check("timeout_cause", done_cause, CAUSE_TIMEOUT);
    check("timeout_cycle_count", cycle_count, 300);
    check("timeout_instr_count", instr_count, 75);
    check("timeout_halt_pc", halt_pc, 32'd1184);

    // Trace: x0 writes skipped, order preserved, head held while not ready
    do_reset();
    fetch(32'h40, NOP);
    for (int i = 0; i < 4; i++) begin
      rf_write(tbl_a[i].addr, tbl_a[i].data);
      if (tbl_a[i].addr != 5'd0) exp_q.push_back({32'h40, tbl_a[i].addr, tbl_a[i].data});
      check($sformatf("trace_valid_%0d", i), trace_valid, tbl_a[i].exp_valid);
      check($sformatf("trace_ovf_%0d", i), trace_overflow, tbl_a[i].exp_ovf);
    end
    idle(2);
    check("trace_head_hold", {trace_pc, trace_addr, trace_data}, exp_q[0]);
    drain("trace_a", 8);

    // Fill to depth, push+pop at full, then one dropped push
    do_reset();
    fetch(32'h80, NOP);
    for (int i = 0; i < 8; i++) begin
      rf_write(tbl_b[i].addr, tbl_b[i].data);
      exp_q.push_back({32'h80, tbl_b[i].addr, tbl_b[i].data});
      check($sformatf("fill_valid_%0d", i), trace_valid, tbl_b[i].exp_valid);
      check($sformatf("fill_ovf_%0d", i), trace_overflow, tbl_b[i].exp_ovf);
    end
    check("full_head", {trace_pc, trace_addr, trace_data}, exp_q[0]);
    rf_we = 1'b1; rf_waddr = 5'd20; rf_wdata = 32'hAAA; trace_ready = 1'b1;
    tick();
    rf_we = 1'b0; trace_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({32'h80, 5'd20, 32'hAAA});
    check("full_pushpop_ovf", trace_overflow, 0);
    check("full_pushpop_head", {trace_pc, trace_addr, trace_data}, exp_q[0]);
    rf_write(5'd21, 32'hBBB);
    check("full_drop_ovf", trace_overflow, 1);
    drain("trace_b", 12);
    check("ovf_sticky", trace_overflow, 1);

    // EBREAK coinciding with the stuck limit
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fetch(32'h20, NOP); idle(1);
    end
    check("ebk_not_yet", done, 0);
    fetch(32'h20, EBK);
    check("ebk_stuck_done", done, 1);
`ifdef RV_MON_EBREAK_HALT_EN
    check("ebk_stuck_cause", done_cause, CAUSE_EBREAK);
`else
    check("ebk_stuck_cause", done_cause, CAUSE_STUCK);
`endif
    check("ebk_stuck_halt_pc", halt_pc, 32'h20);
    check("ebk_stuck_instr", instr_count, 6);

    // EBREAK at a fresh PC
    do_reset();
    fetch(32'h0, NOP);
    fetch(32'h4, EBK);
    idle(1);
    check("ebk_alone_instr", instr_count, 2);
`ifdef RV_MON_EBREAK_HALT_EN
    check("ebk_alone_done", done, 1);
    check("ebk_alone_cause", done_cause, CAUSE_EBREAK);
    check("ebk_alone_halt_pc", halt_pc, 32'h4);
`else
    check("ebk_alone_done", done, 0);
    check("ebk_alone_cause", done_cause, CAUSE_NONE);
`endif

    // Reset in the middle of a run with trace entries pending
    do_reset();
    fetch(32'h60, NOP); idle(2);
    rf_write(5'd3, 32'h33);
    rf_write(5'd4, 32'h44);
    check("midreset_pre_valid", trace_valid, 1);
    check("midreset_pre_cycle", cycle_count, 4);
    reset = 1'b0;
    tick();
    check_zero_outputs("midreset");
    reset = 1'b1;
    idle(1);
    check("midreset_still_empty", trace_valid, 0);
    check("midreset_idle_cycle", cycle_count, 0);
    fetch(32'h200, NOP);
    check("restart_instr", instr_count, 1);
    check("restart_cycle0", cycle_count, 0);
    idle(2);
    check("restart_cycle2", cycle_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
